// File: rtl/result_fifo.sv
// Result queue between the arithmetic unit and the file writer.
// Circular buffer with registered occupancy; handshakes depend only on held state and rst.
module result_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           input_z,
   input  logic                       input_z_stb,
   output logic                       input_z_ack,
   output logic [WIDTH-1:0]           output_z,
   output logic                       output_z_stb,
   input  logic                       output_z_ack,
   output logic [$clog2(DEPTH):0]     count,
   output logic [31:0]                total
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             push;
   logic             pop;

   // rst gating keeps both handshakes low during reset, so no transfer can occur then
   always_comb begin
      input_z_ack  = rst && (count < FULL);
      output_z_stb = rst && (count != '0);
      push         = input_z_stb && input_z_ack;
      pop          = output_z_stb && output_z_ack;
      output_z     = storage[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (push) begin
         storage[wr_ptr] <= input_z;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         total  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            total  <= total + 32'd1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_result_fifo.sv
// Self-checking bench for result_fifo: vector table, hand sequences and a queue scoreboard.
module tb_result_fifo;

   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] input_z = '0;
   logic        input_z_stb = 1'b0;
   logic        input_z_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack = 1'b0;
   logic [3:0]  count;
   logic [31:0] total;

   result_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .input_z(input_z), .input_z_stb(input_z_stb), .input_z_ack(input_z_ack),
      .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
      .count(count), .total(total)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          stb;
      logic [31:0] din;
      bit          ack;
      int          exp_count;
      bit          exp_in_ack;
      bit          exp_out_stb;
      int          exp_total;
   } vec_t;

   vec_t        vt[$];
   logic [31:0] sb[$];
   int          m_total = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs, check pre-edge handshakes against the model, clock, update model.
   task automatic cycle(input bit stb, input logic [31:0] din, input bit ack);
      bit push_e, pop_e;
      input_z_stb  = stb;
      input_z      = din;
      output_z_ack = ack;
      #1;
      chk("input_z_ack", {63'd0, input_z_ack}, {63'd0, rst && (sb.size() < DEPTH)});
      chk("output_z_stb", {63'd0, output_z_stb}, {63'd0, rst && (sb.size() != 0)});
      if (rst && sb.size() != 0) chk("output_z_data", {32'd0, output_z}, {32'd0, sb[0]});
      push_e = rst && stb && (sb.size() < DEPTH);
      pop_e  = rst && ack && (sb.size() != 0);
      @(posedge clk);
      #1;
      if (!rst) begin
         sb.delete();
         m_total = 0;
      end else begin
         if (pop_e) begin
            void'(sb.pop_front());
            m_total++;
         end
         if (push_e) sb.push_back(din);
      end
      chk("count", {60'd0, count}, 64'(sb.size()));
      chk("total", {32'd0, total}, 64'(unsigned'(m_total)));
   endtask

   function automatic vec_t mk(bit s, logic [31:0] d, bit a, int c, bit ia, bit os, int t);
      vec_t v;
      v.stb = s; v.din = d; v.ack = a;
      v.exp_count = c; v.exp_in_ack = ia; v.exp_out_stb = os; v.exp_total = t;
      return v;
   endfunction

   initial begin
      int base;
      // Single word, fill to full, blocked ninth push, in-order drain
      vt.push_back(mk(1, 32'h3F80_0000, 0, 1, 1, 1, 0));
      vt.push_back(mk(0, 32'h0, 1, 0, 1, 0, 1));
      for (int i = 0; i < 8; i++) vt.push_back(mk(1, 32'(i), 0, i + 1, (i + 1) < 8, 1, 1));
      vt.push_back(mk(1, 32'h99, 0, 8, 0, 1, 1));
      for (int i = 0; i < 8; i++) vt.push_back(mk(0, 32'h0, 1, 7 - i, 1, (7 - i) != 0, 2 + i));

      rst = 1'b0;
      cycle(1, 32'h55, 1);
      cycle(0, 32'h0, 0);
      rst = 1'b1;
      #1;
      chk("reset_in_ack", {63'd0, input_z_ack}, 64'd1);
      chk("reset_out_stb", {63'd0, output_z_stb}, 64'd0);
      chk("reset_count", {60'd0, count}, 64'd0);
      chk("reset_total", {32'd0, total}, 64'd0);

      foreach (vt[i]) begin
         cycle(vt[i].stb, vt[i].din, vt[i].ack);
         chk("vec_count", {60'd0, count}, 64'(vt[i].exp_count));
         chk("vec_in_ack", {63'd0, input_z_ack}, {63'd0, vt[i].exp_in_ack});
         chk("vec_out_stb", {63'd0, output_z_stb}, {63'd0, vt[i].exp_out_stb});
         chk("vec_total", {32'd0, total}, 64'(vt[i].exp_total));
      end

      // Full: pop-only edge, then simultaneous push and pop
      for (int i = 0; i < 8; i++) cycle(1, 32'h200 + 32'(i), 0);
      chk("full_count", {60'd0, count}, 64'd8);
      cycle(1, 32'hAA, 1);
      chk("full_pop_count", {60'd0, count}, 64'd7);
      chk("full_pop_in_ack", {63'd0, input_z_ack}, 64'd1);
      cycle(1, 32'hBB, 1);
      chk("pushpop_count", {60'd0, count}, 64'd7);
      chk("pushpop_total", {32'd0, total}, 64'd11);
      for (int i = 0; i < 7; i++) cycle(0, 32'h0, 1);
      chk("drain2_count", {60'd0, count}, 64'd0);

      // Streaming across pointer wrap
      base = m_total;
      for (int i = 0; i < 20; i++) begin
         cycle(1, 32'h100 + 32'(i), 1);
         chk("wrap_count_le1", {63'd0, count <= 4'd1}, 64'd1);
      end
      cycle(0, 32'h0, 1);
      chk("wrap_total", {32'd0, total}, 64'(unsigned'(base + 20)));

      // Reset mid-operation with a pop requested on the reset edge
      for (int i = 0; i < 5; i++) cycle(1, 32'h300 + 32'(i), 0);
      chk("pre_reset_count", {60'd0, count}, 64'd5);
      rst = 1'b0;
      cycle(1, 32'h3FF, 1);
      rst = 1'b1;
      #1;
      chk("midreset_count", {60'd0, count}, 64'd0);
      chk("midreset_total", {32'd0, total}, 64'd0);
      chk("midreset_out_stb", {63'd0, output_z_stb}, 64'd0);
      chk("midreset_in_ack", {63'd0, input_z_ack}, 64'd1);

      // Random backpressure against the scoreboard
      for (int i = 0; i < 10000; i++) begin
         cycle(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)));
         chk("rand_count_max", {63'd0, count <= 4'd8}, 64'd1);
      end
      for (int i = 0; i < 9; i++) cycle(0, 32'h0, 1);
      chk("final_empty", {60'd0, count}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
